// File: rtl/riscv_regfile_pkg.sv
// Shared types and default sizing for the multi-ported RISC-V register file.
// Imported by the top and by the dump sequencer.
package riscv_regfile_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_N_READ     = 3;
    localparam int DEF_N_WRITE    = 2;
    localparam int DEF_BYPASS     = 1;
    localparam int CONFLICT_CNT_W = 8;

    typedef enum logic {
        IDLE,
        STREAM
    } dump_state_e;

endpackage

// File: rtl/riscv_regfile_dump_fsm.sv
// Debug dump sequencer: walks every register address once and presents each word
// on a valid/ready stream, pulsing done after the final beat is accepted.
module riscv_regfile_dump_fsm
    import riscv_regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  ready_i,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic                  valid_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  done_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    dump_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;

    // Storage is looked up one address ahead so the next beat's word is ready at the accept edge.
    assign rd_addr_o = addr_q + 1'b1;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    addr_d  = '0;
                    data_d  = '0;
                    valid_d = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (valid_q && ready_i) begin
                    if (addr_q == LAST_ADDR) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        addr_d = addr_q + 1'b1;
                        data_d = rd_data_i;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;
    assign done_o  = done_q;

endmodule

// File: rtl/riscv_regfile_mp.sv
// Multi-ported register file: x0 hardwired to zero, highest write port wins on collision,
// optional same-cycle write bypass, power-down gating and a debug dump stream.
module riscv_regfile_mp
    import riscv_regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int N_READ     = DEF_N_READ,
    parameter int N_WRITE    = DEF_N_WRITE,
    parameter int BYPASS     = DEF_BYPASS
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                test_en_i,
    input  logic                                pwd_i,
    input  logic [N_READ-1:0][ADDR_WIDTH-1:0]   raddr_i,
    output logic [N_READ-1:0][DATA_WIDTH-1:0]   rdata_o,
    input  logic [N_WRITE-1:0][ADDR_WIDTH-1:0]  waddr_i,
    input  logic [N_WRITE-1:0][DATA_WIDTH-1:0]  wdata_i,
    input  logic [N_WRITE-1:0]                  we_i,
    output logic                                wr_conflict_o,
    output logic [CONFLICT_CNT_W-1:0]           conflict_cnt_o,
    input  logic                                dump_start_i,
    output logic                                dump_valid_o,
    input  logic                                dump_ready_i,
    output logic [ADDR_WIDTH-1:0]               dump_addr_o,
    output logic [DATA_WIDTH-1:0]               dump_data_o,
    output logic                                dump_done_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]     mem_q [DEPTH];
    logic [N_WRITE-1:0]        commit;
    logic                      collision;
    logic                      wr_conflict_q;
    logic [CONFLICT_CNT_W-1:0] conflict_cnt_q;
    logic [ADDR_WIDTH-1:0]     dump_rd_addr;
    logic [DATA_WIDTH-1:0]     dump_rd_data;

    always_comb begin
        for (int i = 0; i < N_WRITE; i++) begin
            commit[i] = we_i[i] && (waddr_i[i] != '0) && !pwd_i;
        end
    end

    always_comb begin
        collision = 1'b0;
        for (int i = 0; i < N_WRITE; i++) begin
            for (int k = i + 1; k < N_WRITE; k++) begin
                if (commit[i] && commit[k] && (waddr_i[i] == waddr_i[k])) begin
                    collision = 1'b1;
                end
            end
        end
    end

    // Ascending port order: a later (higher-index) match overrides, giving it priority.
    always_comb begin
        for (int j = 0; j < N_READ; j++) begin
            rdata_o[j] = '0;
            if ((raddr_i[j] != '0) && !pwd_i) begin
                rdata_o[j] = mem_q[raddr_i[j]];
                if ((BYPASS != 0) && !test_en_i) begin
                    for (int i = 0; i < N_WRITE; i++) begin
                        if (commit[i] && (waddr_i[i] == raddr_i[j])) begin
                            rdata_o[j] = wdata_i[i];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem_q[a] <= '0;
            end
        end else begin
            for (int i = 0; i < N_WRITE; i++) begin
                if (commit[i]) begin
                    mem_q[waddr_i[i]] <= wdata_i[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_conflict_q  <= 1'b0;
            conflict_cnt_q <= '0;
        end else begin
            wr_conflict_q <= collision;
            if (collision && (conflict_cnt_q != '1)) begin
                conflict_cnt_q <= conflict_cnt_q + 1'b1;
            end
        end
    end

    assign wr_conflict_o  = wr_conflict_q;
    assign conflict_cnt_o = conflict_cnt_q;
    assign dump_rd_data   = mem_q[dump_rd_addr];

    riscv_regfile_dump_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_dump (
        .clk       (clk),
        .rst       (rst),
        .start_i   (dump_start_i),
        .ready_i   (dump_ready_i),
        .rd_data_i (dump_rd_data),
        .rd_addr_o (dump_rd_addr),
        .valid_o   (dump_valid_o),
        .addr_o    (dump_addr_o),
        .data_o    (dump_data_o),
        .done_o    (dump_done_o)
    );

endmodule
